// File: rtl/icache_pkg.sv
`default_nettype none
// ============================================================================
// Module      : icache_pkg
// Description : Shared types, widths and address field helpers for the
//               direct-mapped L1 instruction cache.
//               Contents: state_t (S_IDLE/S_ALLOC/S_FILL), LINE_W, WORD_W,
//               OFFSET_W, ADDR_W, LADDR_W, get_tag/get_idx/get_off.
// Revision    : 1.0 - initial release
// ============================================================================
package icache_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ALLOC = 2'd1,
        S_FILL  = 2'd2
    } state_t;

    localparam int LINE_W   = 128;
    localparam int WORD_W   = 32;
    localparam int OFFSET_W = 2;
    localparam int WORDS    = 4;
    localparam int ADDR_W   = 30;
    localparam int LADDR_W  = ADDR_W - OFFSET_W;

    // Index field, right-justified; the caller narrows it to its index width.
    function automatic logic [ADDR_W-1:0] get_idx(input logic [ADDR_W-1:0] addr,
                                                  input int index_w);
        return (addr >> OFFSET_W) & ((ADDR_W'(1) << index_w) - ADDR_W'(1));
    endfunction

    // Tag field, right-justified; the caller narrows it to its tag width.
    function automatic logic [ADDR_W-1:0] get_tag(input logic [ADDR_W-1:0] addr,
                                                  input int index_w);
        return addr >> (OFFSET_W + index_w);
    endfunction

    function automatic logic [OFFSET_W-1:0] get_off(input logic [ADDR_W-1:0] addr);
        return addr[OFFSET_W-1:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/icache_line_array.sv
`default_nettype none
// ============================================================================
// Module      : icache_line_array
// Description : Tag, valid and data storage for the direct-mapped I-cache.
//               One combinational read port, one synchronous write port.
//               The valid bits clear asynchronously on rst; tag and data
//               storage is never reset.
// Ports       : clk, rst            clock / async active-high valid clear
//               i_rd_idx            read index
//               o_rd_valid/tag/data read results (combinational)
//               i_we, i_wr_idx      write enable / write index
//               i_wr_tag, i_wr_data line written together with valid = 1
// Revision    : 1.0 - initial release
// ============================================================================
module icache_line_array
    import icache_pkg::*;
#(
    parameter int LINES   = 8,
    parameter int INDEX_W = $clog2(LINES),
    parameter int TAG_W   = LADDR_W - INDEX_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INDEX_W-1:0] i_rd_idx,
    output logic               o_rd_valid,
    output logic [TAG_W-1:0]   o_rd_tag,
    output logic [LINE_W-1:0]  o_rd_data,
    input  logic               i_we,
    input  logic [INDEX_W-1:0] i_wr_idx,
    input  logic [TAG_W-1:0]   i_wr_tag,
    input  logic [LINE_W-1:0]  i_wr_data
);

    logic [LINES-1:0]  r_valid;
    logic [TAG_W-1:0]  r_tag  [LINES];
    logic [LINE_W-1:0] r_data [LINES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
        end else if (i_we) begin
            r_valid[i_wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_tag[i_wr_idx]  <= i_wr_tag;
            r_data[i_wr_idx] <= i_wr_data;
        end
    end

    assign o_rd_valid = r_valid[i_rd_idx];
    assign o_rd_tag   = r_tag[i_rd_idx];
    assign o_rd_data  = r_data[i_rd_idx];

endmodule
`default_nettype wire

// File: rtl/l1_icache_dm.sv
`default_nettype none
// ============================================================================
// Module      : l1_icache_dm
// Description : Read-only direct-mapped L1 instruction cache, 4-word lines.
//               Hits return the word combinationally in the request cycle.
//               A miss stalls, fetches one 128-bit line, fills it, and the
//               following idle cycle re-looks up and hits.
// Ports       : clk, proc_reset (async, active-high)
//               proc_read/write/addr/wdata  pipeline request (writes ignored)
//               proc_stall/rdata            pipeline response
//               mem_read/write/addr/wdata   line-fill request (write tied 0)
//               mem_rdata/mem_ready         line-fill response (ready pulse)
//               hit_cnt/miss_cnt            present with ICACHE_PERF_CNT_EN
// Options     : ICACHE_PERF_CNT_EN - adds 32-bit hit/miss counters
// Revision    : 1.0 - initial release
// ============================================================================
module l1_icache_dm
    import icache_pkg::*;
#(
    parameter int LINES = 8
) (
    input  logic                clk,
    input  logic                proc_reset,
    input  logic                proc_read,
    input  logic                proc_write,
    input  logic [ADDR_W-1:0]   proc_addr,
    input  logic [WORD_W-1:0]   proc_wdata,
    output logic                proc_stall,
    output logic [WORD_W-1:0]   proc_rdata,
    output logic                mem_read,
    output logic                mem_write,
    output logic [LADDR_W-1:0]  mem_addr,
    output logic [LINE_W-1:0]   mem_wdata,
    input  logic [LINE_W-1:0]   mem_rdata,
    input  logic                mem_ready
`ifdef ICACHE_PERF_CNT_EN
    ,
    output logic [31:0]         hit_cnt,
    output logic [31:0]         miss_cnt
`endif
);

    localparam int INDEX_W = $clog2(LINES);
    localparam int TAG_W   = LADDR_W - INDEX_W;

    state_t              r_state;
    state_t              w_next;
    logic [LADDR_W-1:0]  r_miss_addr;
    logic [LINE_W-1:0]   r_fill_buf;

    logic [INDEX_W-1:0]  w_idx;
    logic [TAG_W-1:0]    w_tag;
    logic [OFFSET_W-1:0] w_off;
    logic                w_rd_valid;
    logic [TAG_W-1:0]    w_rd_tag;
    logic [LINE_W-1:0]   w_rd_data;
    logic                w_hit;
    logic                w_hit_idle;
    logic                w_miss_start;
    logic                w_fill_latch;
    logic                w_fill_we;

    assign w_idx = INDEX_W'(get_idx(proc_addr, INDEX_W));
    assign w_tag = TAG_W'(get_tag(proc_addr, INDEX_W));
    assign w_off = get_off(proc_addr);
    assign w_hit = proc_read & w_rd_valid & (w_rd_tag == w_tag);

    icache_line_array #(
        .LINES   (LINES),
        .INDEX_W (INDEX_W),
        .TAG_W   (TAG_W)
    ) u_lines (
        .clk        (clk),
        .rst        (proc_reset),
        .i_rd_idx   (w_idx),
        .o_rd_valid (w_rd_valid),
        .o_rd_tag   (w_rd_tag),
        .o_rd_data  (w_rd_data),
        .i_we       (w_fill_we),
        .i_wr_idx   (r_miss_addr[INDEX_W-1:0]),
        .i_wr_tag   (r_miss_addr[LADDR_W-1:INDEX_W]),
        .i_wr_data  (r_fill_buf)
    );

    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Fill datapath carries no reset: it is only consumed after being loaded.
    always_ff @(posedge clk) begin
        if (w_miss_start) begin
            r_miss_addr <= proc_addr[ADDR_W-1:OFFSET_W];
        end
        if (w_fill_latch) begin
            r_fill_buf <= mem_rdata;
        end
    end

    always_comb begin
        w_next       = r_state;
        proc_stall   = 1'b0;
        proc_rdata   = '0;
        mem_read     = 1'b0;
        mem_addr     = proc_addr[ADDR_W-1:OFFSET_W];
        w_hit_idle   = 1'b0;
        w_miss_start = 1'b0;
        w_fill_latch = 1'b0;
        w_fill_we    = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Lookups are suppressed while reset is held so the outputs
                // stay at their reset values.
                if (proc_read && !proc_reset) begin
                    if (w_hit) begin
                        proc_rdata = w_rd_data[{w_off, 5'b0} +: WORD_W];
                        w_hit_idle = 1'b1;
                    end else begin
                        proc_stall   = 1'b1;
                        w_miss_start = 1'b1;
                        w_next       = S_ALLOC;
                    end
                end
            end
            S_ALLOC: begin
                mem_read   = 1'b1;
                mem_addr   = r_miss_addr;
                proc_stall = 1'b1;
                if (mem_ready) begin
                    w_fill_latch = 1'b1;
                    w_next       = S_FILL;
                end
            end
            S_FILL: begin
                proc_stall = 1'b1;
                w_fill_we  = 1'b1;
                w_next     = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    assign mem_write = 1'b0;
    assign mem_wdata = '0;

    // Write data has no destination in a read-only cache.
    logic w_unused_wdata;
    assign w_unused_wdata = ^proc_wdata;

`ifdef ICACHE_PERF_CNT_EN
    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (w_hit_idle) begin
                hit_cnt <= hit_cnt + 32'd1;
            end
            if (w_miss_start) begin
                miss_cnt <= miss_cnt + 32'd1;
            end
        end
    end
`else
    logic w_unused_perf;
    assign w_unused_perf = w_hit_idle;
`endif

    a_no_write: assert property (@(posedge clk) disable iff (proc_reset) proc_write == 1'b0);

endmodule
`default_nettype wire
